// File: rtl/upc_sched_pkg.sv
// -----------------------------------------------------------------------------
// upc_sched_pkg
//   Shared types and defaults for the interval scheduler slice.
//   - upc_sched_state_t : scheduler FSM state encoding
//   - UPC_DEF_WIDTH     : default counter width
//   - UPC_DEF_NREQ      : default number of requesters
// -----------------------------------------------------------------------------
package upc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } upc_sched_state_t;

  localparam int UPC_DEF_WIDTH = 4;
  localparam int UPC_DEF_NREQ  = 4;

endpackage

// File: rtl/upc_core.sv
// -----------------------------------------------------------------------------
// upc_core
//   Loadable WIDTH-bit up-counter shared by the interval scheduler.
//   Ports:
//     clk       in  : rising-edge clock
//     rst       in  : asynchronous, active-low reset (counter -> 0)
//     ld_i      in  : parallel load of par_in_i (wins over cen_i)
//     cen_i     in  : count enable, +1 per enabled cycle
//     par_in_i  in  : load value
//     par_out_o out : current counter value
//     co_o      out : carry-out condition, counter is all-ones
// -----------------------------------------------------------------------------
module upc_core
  import upc_sched_pkg::*;
#(
  parameter int WIDTH = UPC_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic             cen_i,
  input  logic [WIDTH-1:0] par_in_i,
  output logic [WIDTH-1:0] par_out_o,
  output logic             co_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = par_in_i;
    end else if (cen_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign par_out_o = cnt_q;
  // Terminal detection does not depend on cen_i, so the scheduler can stop
  // on all-ones regardless of tick.
  assign co_o      = &cnt_q;

endmodule

// File: rtl/upc_interval_sched.sv
// -----------------------------------------------------------------------------
// upc_interval_sched
//   Round-robin scheduler sharing one upc_core counter among NREQ requesters.
//   A winner's start value is loaded, counted up on tick strobes to all-ones,
//   then the winner gets a one-cycle done pulse.
//
//   Handshake: req_i[i] is a level; the requester raises it and holds it until
//   it sees done_o[i]. gnt_o[i] marks ownership of the counter from the grant
//   edge through the DONE cycle. Other req_i bits are only looked at in IDLE.
//
//   Ports:
//     clk, rst      : clock, asynchronous active-low reset
//     req_i         : per-requester request level
//     start_val_i   : packed start values, slice i = [i*WIDTH +: WIDTH]
//     tick_i        : count-enable strobe
//     gnt_o         : one-hot grant, zero when idle
//     busy_o        : high whenever the FSM is not in IDLE
//     done_o        : one-hot one-cycle completion pulse
//     cnt_out_o     : current counter value
//     state_o       : FSM state (debug visibility)
//
//   Build option: define UPC_SCHED_ABORT_EN to let a granted requester cancel
//   its interval by dropping req during LOAD or COUNT (no done pulse).
// -----------------------------------------------------------------------------
module upc_interval_sched
  import upc_sched_pkg::*;
#(
  parameter int NREQ  = UPC_DEF_NREQ,
  parameter int WIDTH = UPC_DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] start_val_i,
  input  logic                  tick_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  busy_o,
  output logic [NREQ-1:0]       done_o,
  output logic [WIDTH-1:0]      cnt_out_o,
  output upc_sched_state_t      state_o
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  upc_sched_state_t  state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              busy_q;
  logic [IDXW-1:0]   last_q;
  logic [IDXW-1:0]   gidx_q;

  logic [IDXW-1:0]   pick_idx;
  logic [WIDTH-1:0]  ld_val;
  logic [WIDTH-1:0]  cnt;
  logic              co;
  logic              ld;
  logic              cen;
  logic              abort;

  // Round-robin search starting one past the last served requester.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDXW-1:0] last);
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] idx;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDXW'((int'(last) + k) % NREQ);
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  assign pick_idx = rr_pick(req_i, last_q);

  // Start value of the current grant holder (gnt_q is one-hot or zero).
  always_comb begin
    ld_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        ld_val = ld_val | start_val_i[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef UPC_SCHED_ABORT_EN
  assign abort = ((state_q == ST_LOAD) || (state_q == ST_COUNT)) &&
                 ((req_i & gnt_q) == '0);
`else
  assign abort = 1'b0;
`endif

  // All-ones check in COUNT outranks tick, so the counter never wraps.
  assign ld  = (state_q == ST_LOAD) && !abort;
  assign cen = (state_q == ST_COUNT) && tick_i && !co && !abort;

  upc_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (ld),
    .cen_i    (cen),
    .par_in_i (ld_val),
    .par_out_o(cnt),
    .co_o     (co)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= IDXW'(NREQ - 1);
      gidx_q  <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req_i) begin
            gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            gidx_q  <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= gidx_q;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (abort) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= gidx_q;
            state_q <= ST_IDLE;
          end else if (co) begin
            done_q  <= gnt_q;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          last_q  <= gidx_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cnt_out_o = cnt;
  assign state_o   = state_q;

endmodule

// File: tb/tb_upc_interval_sched.sv
// -----------------------------------------------------------------------------
// tb_upc_interval_sched
//   Directed bench for upc_interval_sched (NREQ=4, WIDTH=4): a table of
//   full intervals with hand-computed grants, load values and done latency,
//   plus sequences for tick gating, reset mid-count and requester abort.
// -----------------------------------------------------------------------------
module tb_upc_interval_sched;
  import upc_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] start_val = '0;
  logic                  tick = 1'b0;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      cnt;
  upc_sched_state_t      state;

  always #5 clk = ~clk;

  upc_interval_sched #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .start_val_i(start_val),
    .tick_i     (tick),
    .gnt_o      (gnt),
    .busy_o     (busy),
    .done_o     (done),
    .cnt_out_o  (cnt),
    .state_o    (state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] sv;
    logic [NREQ-1:0]       exp_gnt;
    logic [WIDTH-1:0]      exp_load;
    int                    exp_done_edge;  // edge index (E0 = 0) that enters DONE
  } vec_t;

  vec_t vecs[9];

  // One full interval with tick held high; every count step is checked
  // against the expected queue.
  task automatic run_vector(input vec_t v, input string tag);
    int n;
    logic [WIDTH-1:0] e;
    req       = v.req;
    start_val = v.sv;
    tick      = 1'b1;
    edge_step();  // E0
    check({tag, "_gnt"}, 32'(gnt), 32'(v.exp_gnt));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    edge_step();  // E1
    check({tag, "_load"}, 32'(cnt), 32'(v.exp_load));
    exp_q.delete();
    for (int x = int'(v.exp_load) + 1; x <= 15; x++) exp_q.push_back(WIDTH'(x));
    n = 1;
    while (done == '0 && n < 40) begin
      edge_step();
      n++;
      if (done == '0 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({tag, "_cnt"}, 32'(cnt), 32'(e));
      end
    end
    check({tag, "_done_edge"}, 32'(n), 32'(v.exp_done_edge));
    check({tag, "_done"}, 32'(done), 32'(v.exp_gnt));
    check({tag, "_cnt_final"}, 32'(cnt), 32'hF);
    check({tag, "_gnt_held"}, 32'(gnt), 32'(v.exp_gnt));
    check({tag, "_steps_left"}, 32'(exp_q.size()), 32'd0);
    edge_step();  // DONE -> IDLE
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
    check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    req = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] m_cnt;
    logic             fin;
    int               n;

    // req, start_val, gnt, loaded value, DONE edge (2 + 15 - start)
    vecs[0] = '{4'b0001, 16'h000C, 4'b0001, 4'hC, 5};
    vecs[1] = '{4'b1111, 16'h12F3, 4'b0010, 4'hF, 2};
    vecs[2] = '{4'b1111, 16'h4D56, 4'b0100, 4'hD, 4};
    vecs[3] = '{4'b1111, 16'hE123, 4'b1000, 4'hE, 3};
    vecs[4] = '{4'b1111, 16'h789B, 4'b0001, 4'hB, 6};
    vecs[5] = '{4'b1010, 16'h30E0, 4'b0010, 4'hE, 3};
    vecs[6] = '{4'b1001, 16'hC00F, 4'b1000, 4'hC, 5};
    vecs[7] = '{4'b0100, 16'h0000, 4'b0100, 4'h0, 17};
    vecs[8] = '{4'b0011, 16'h5678, 4'b0001, 4'h8, 9};

    // reset state
    #12;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    rst = 1'b1;
    edge_step();

    // table of full intervals, round-robin state carries across entries
    for (int i = 0; i < 9; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // tick gating: last served is 0, so 0001 alone wins; tick every 3rd cycle
    req       = 4'b0001;
    start_val = 16'h000E;
    tick      = 1'b0;
    edge_step();
    check("tg_gnt", 32'(gnt), 32'b0001);
    edge_step();
    check("tg_load", 32'(cnt), 32'hE);
    m_cnt = 4'hE;
    fin   = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      tick = (c % 3 == 2);
      edge_step();
      if (m_cnt == 4'hF) begin
        fin = 1'b1;
        check("tg_done", 32'(done), 32'b0001);
      end else begin
        if (tick) m_cnt = m_cnt + 4'd1;
        check("tg_no_done", 32'(done), 32'd0);
      end
      check("tg_cnt", 32'(cnt), 32'(m_cnt));
    end
    tick = 1'b0;
    edge_step();
    check("tg_done_clr", 32'(done), 32'd0);
    check("tg_gnt_clr", 32'(gnt), 32'd0);
    req  = '0;
    tick = 1'b1;

    // reset mid-count at 0xA
    req       = 4'b0100;
    start_val = 16'h0700;
    edge_step();
    check("rm_gnt", 32'(gnt), 32'b0100);
    for (int k = 0; k < 4; k++) edge_step();
    check("rm_cnt_a", 32'(cnt), 32'hA);
    rst = 1'b0;
    #1;
    check("rm_gnt0", 32'(gnt), 32'd0);
    check("rm_busy0", 32'(busy), 32'd0);
    check("rm_done0", 32'(done), 32'd0);
    check("rm_cnt0", 32'(cnt), 32'd0);
    check("rm_state", 32'(state), 32'(ST_IDLE));
    #2;
    rst       = 1'b1;
    req       = 4'b1001;  // last back at 3 -> requester 0 first
    start_val = 16'h000F;
    edge_step();
    check("rm_regrant", 32'(gnt), 32'b0001);
    edge_step();
    edge_step();
    check("rm_done", 32'(done), 32'b0001);
    edge_step();
    check("rm_idle", 32'(busy), 32'd0);
    req = '0;

    // requester 1 drops its request mid-count
    req       = 4'b0010;
    start_val = 16'h0000;
    edge_step();
    check("ab_gnt", 32'(gnt), 32'b0010);
    edge_step();
    edge_step();
    check("ab_cnt1", 32'(cnt), 32'h1);
    req = '0;
    edge_step();
`ifdef UPC_SCHED_ABORT_EN
    check("ab_gnt_clr", 32'(gnt), 32'd0);
    check("ab_busy_clr", 32'(busy), 32'd0);
    check("ab_state", 32'(state), 32'(ST_IDLE));
    for (int k = 0; k < 3; k++) begin
      edge_step();
      check("ab_no_done", 32'(done), 32'd0);
    end
    req       = 4'b0011;  // last is 1 -> search 2,3,0
    start_val = 16'h000F;
    edge_step();
    check("ab_next_gnt", 32'(gnt), 32'b0001);
    edge_step();
    edge_step();
    check("ab_next_done", 32'(done), 32'b0001);
    edge_step();
    req = '0;
`else
    check("ab_gnt_held", 32'(gnt), 32'b0010);
    check("ab_busy_held", 32'(busy), 32'd1);
    check("ab_cnt2", 32'(cnt), 32'h2);
    n = 3;
    while (done == '0 && n < 40) begin
      edge_step();
      n++;
    end
    check("ab_done_edge", 32'(n), 32'd17);
    check("ab_done", 32'(done), 32'b0010);
    edge_step();
    check("ab_idle", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
